mult_div_unit: RTL and testbench

- Iterative multiply/divide unit in the EX stage of the pipelined MIPS core.
- Consumes the two register-file read operands, as carried through the ID/EX register, and executes MULT, MULTU, DIV and DIVU over 32 cycles.
- Holds the architectural HI/LO registers for MFHI/MFLO, and accepts MTHI/MTLO writes.
- Drives `busy` to the hazard unit, which stalls IF/ID/EX while the unit is working.

---
 rtl/mdu_pkg.sv | 18 +
 rtl/mdu_step.sv | 30 +++
 rtl/mult_div_unit.sv | 118 +++++++++++
 tb/tb_mult_div_unit.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states, width.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DIV  = 2'b10,
    FIN  = 2'b11
  } mdu_state_e;

endpackage

// File: rtl/mdu_step.sv
// One iteration of the unsigned datapath: shift-add multiply or restoring divide
// on a {upper, lower} double-width accumulator.
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0]   operand,
  input  logic               is_div,
  output logic [2*WIDTH-1:0] acc_out
);

  logic [WIDTH:0] mul_sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] trial;

  // Multiply: the multiplier sits in the lower half and is consumed LSB first.
  // Divide: the lower half holds the dividend being shifted out and the
  // quotient bits being shifted in; the shifted remainder needs WIDTH+1 bits.
  always_comb begin
    mul_sum = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + (acc_in[0] ? {1'b0, operand} : '0);
    rem_sh  = {acc_in[2*WIDTH-1:WIDTH], acc_in[WIDTH-1]};
    trial   = rem_sh - {1'b0, operand};
    acc_out = {mul_sum, acc_in[WIDTH-1:1]};
    if (is_div) begin
      if (!trial[WIDTH]) acc_out = {trial[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b1};
      else               acc_out = {rem_sh[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO registers.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  // Handshake: start is taken only while busy=0; busy then stays high until
  // the result is written, and done pulses for one cycle with HI/LO valid.
  mdu_state_e state, state_nxt;

  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc, acc_nxt, prod;
  logic [WIDTH-1:0]   opb, a_mag, b_mag, quot, rem, hi_res, lo_res;
  logic               neg_res, neg_rem, dz, div_op, is_signed, last_step;

  assign is_signed = ~op[0];
  assign a_mag     = (is_signed && srca[WIDTH-1]) ? -srca : srca;
  assign b_mag     = (is_signed && srcb[WIDTH-1]) ? -srcb : srcb;
  assign last_step = (count == CW'(WIDTH - 1));

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .acc_in (acc),
    .operand(opb),
    .is_div (state == DIV),
    .acc_out(acc_nxt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start) state_nxt = op[1] ? DIV : MUL;
      MUL, DIV: if (last_step) state_nxt = FIN;
      FIN:      state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  // Sign fixup from magnitudes; a zero divisor leaves the dividend as remainder.
  always_comb begin
    prod   = neg_res ? -acc : acc;
    quot   = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem    = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    hi_res = prod[2*WIDTH-1:WIDTH];
    lo_res = prod[WIDTH-1:0];
    if (div_op) begin
      hi_res = rem;
      lo_res = dz ? '1 : quot;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count   <= '0;
      acc     <= '0;
      opb     <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      dz      <= 1'b0;
      div_op  <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      done <= (state == FIN);
      case (state)
        IDLE: begin
          if (start) begin
            count   <= '0;
            acc     <= {{WIDTH{1'b0}}, a_mag};
            opb     <= b_mag;
            neg_res <= is_signed & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
            neg_rem <= is_signed & srca[WIDTH-1];
            dz      <= op[1] & (srcb == '0);
            div_op  <= op[1];
          end else begin
            if (mthi) hi <= srca;
            if (mtlo) lo <= srca;
          end
        end
        MUL, DIV: begin
          acc   <= acc_nxt;
          count <= count + 1'b1;
        end
        FIN: begin
          hi <= hi_res;
          lo <= lo_res;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed and random checks of mult_div_unit against a behavioural arithmetic model.
module tb_mult_div_unit;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] srca = '0;
  logic [31:0] srcb = '0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_vec  = 0;
  int n_fail = 0;
  logic [63:0] exp_q[$];

  mult_div_unit #(.WIDTH(32)) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .op   (op),
    .srca (srca),
    .srcb (srcb),
    .mthi (mthi),
    .mtlo (mtlo),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [31:0] q, r;
    model = '0;
    case (o)
      OP_MULT: begin
        sa = $signed(a);
        sb = $signed(b);
        model = sa * sb;
      end
      OP_MULTU: model = {32'h0, a} * {32'h0, b};
      OP_DIV: begin
        if (b == 32'h0) model = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) model = {32'h0, 32'h8000_0000};
        else begin
          q = $signed(a) / $signed(b);
          r = $signed(a) % $signed(b);
          model = {r, q};
        end
      end
      default: begin
        if (b == 32'h0) model = {a, 32'hFFFF_FFFF};
        else model = {a % b, a / b};
      end
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Caller sits at a negedge; launches one op and returns at the negedge where done is seen.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit disturb);
    logic [63:0] res;
    logic [31:0] hold_hi, hold_lo;
    int lat, busy_cnt;
    bit got, hold_ok, overlap;
    exp_q.push_back(model(o, a, b));
    hold_hi = hi;
    hold_lo = lo;
    start = 1'b1; op = o; srca = a; srcb = b;
    @(negedge clk);
    start = 1'b0; srca = $urandom; srcb = $urandom;
    lat = 1; got = 0; busy_cnt = 0; hold_ok = 1; overlap = 0;
    while (lat <= 40 && !got) begin
      if (busy && done) overlap = 1;
      if (done) got = 1;
      else begin
        if (busy) busy_cnt++;
        if (hi !== hold_hi || lo !== hold_lo) hold_ok = 0;
        if (disturb) begin
          if (lat == 5) begin start = 1'b1; op = OP_DIV; srca = 32'd7; srcb = 32'd3; end
          if (lat == 6) start = 1'b0;
          if (lat == 8) begin mthi = 1'b1; srca = 32'hAAAA_5555; end
          if (lat == 9) mthi = 1'b0;
        end
        @(negedge clk);
        lat++;
      end
    end
    check("done_seen", 64'(got), 64'd1);
    res = exp_q.pop_front();
    if (got) begin
      check("latency", 64'(lat), 64'd34);
      check("busy_cycles", 64'(busy_cnt), 64'd33);
      check("hold_hilo", 64'(hold_ok), 64'd1);
      check("busy_done_overlap", 64'(overlap), 64'd0);
      check("hi", {32'h0, hi}, {32'h0, res[63:32]});
      check("lo", {32'h0, lo}, {32'h0, res[31:0]});
    end
  endtask

  initial begin
    logic [31:0] prev_lo;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    repeat (2) @(negedge clk);
    check("rst_busy", {63'h0, busy}, 64'd0);
    check("rst_done", {63'h0, done}, 64'd0);
    check("rst_hi", {32'h0, hi}, 64'd0);
    check("rst_lo", {32'h0, lo}, 64'd0);
    reset = 1'b1;
    @(negedge clk);

    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("multu_max_hi", {32'h0, hi}, 64'hFFFF_FFFE);
    run_op(OP_MULT,  32'hFFFF_FFFD, 32'd5, 1'b0);
    run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2, 1'b0);
    check("div_neg_lo", {32'h0, lo}, 64'hFFFF_FFFD);
    run_op(OP_DIVU,  32'h1234_5678, 32'h0, 1'b0);
    run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(OP_DIV,   32'h8765_4321, 32'h0, 1'b0);

    // Disturbed MULTU, then an idle mthi.
    run_op(OP_MULTU, 32'h0001_0003, 32'h0000_0101, 1'b1);
    prev_lo = lo;
    mthi = 1'b1; srca = 32'hAAAA_5555;
    @(negedge clk);
    mthi = 1'b0;
    check("mthi_hi", {32'h0, hi}, 64'hAAAA_5555);
    check("mthi_lo_kept", {32'h0, lo}, {32'h0, prev_lo});
    mthi = 1'b1; mtlo = 1'b1; srca = 32'h1357_9BDF;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    check("mthilo_hi", {32'h0, hi}, 64'h1357_9BDF);
    check("mthilo_lo", {32'h0, lo}, 64'h1357_9BDF);
    // start wins over a simultaneous move
    start = 1'b1; mtlo = 1'b1; op = OP_MULTU; srca = 32'd3; srcb = 32'd4;
    @(negedge clk);
    start = 1'b0; mtlo = 1'b0;
    check("start_wins_lo", {32'h0, lo}, 64'h1357_9BDF);
    repeat (34) @(negedge clk);
    check("start_wins_res", {32'h0, lo}, 64'd12);

    // Asynchronous reset mid-divide.
    start = 1'b1; op = OP_DIVU; srca = 32'd100; srcb = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b0;
    #1;
    check("arst_busy", {63'h0, busy}, 64'd0);
    check("arst_done", {63'h0, done}, 64'd0);
    check("arst_hi", {32'h0, hi}, 64'd0);
    check("arst_lo", {32'h0, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_op(OP_DIVU, 32'd100, 32'd7, 1'b0);
    check("divu_100_7_lo", {32'h0, lo}, 64'd14);

    // Back-to-back: launched in the done cycle of the previous op.
    run_op(OP_MULT, 32'd6, 32'd7, 1'b0);
    check("mult_6_7_lo", {32'h0, lo}, 64'd42);

    for (int i = 0; i < 8; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i == 3) ? 32'h0 : ((i == 5) ? 32'($urandom_range(1, 9)) : $urandom);
      run_op(ro, ra, rb, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
